// File: rtl/tt_um_hoene_manchester_encoder_pkg.sv
// Shared Manchester line definitions: FSM state encoding, default widths and the
// coding polarity that the decoder also relies on.
package tt_um_hoene_manchester_encoder_pkg;

    localparam int HALF_W_DEF = 6;

    // Line level during the first half of a '1' bit; a '0' bit is the mirror image.
    localparam logic MANCH_ONE_FIRST = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2,
        ST_GAP    = 2'd3
    } enc_state_t;

    function automatic logic first_half_level(input logic d);
        return d ? MANCH_ONE_FIRST : ~MANCH_ONE_FIRST;
    endfunction

endpackage

// File: rtl/tt_um_hoene_halfbit_timer.sv
// Loadable down-counter with zero flag; load wins over counting, holds at zero.
// A load of N gives N+1 cycles until o_zero is seen (N..0 inclusive).
module tt_um_hoene_halfbit_timer
    import tt_um_hoene_manchester_encoder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tt_um_hoene_manchester_encoder.sv
// Manchester transmitter: accepted bit appears on out the next cycle, 2*half cycles per bit.
// in_ready only in IDLE or the final cycle of a non-last bit; a frame ends with an idle gap.
module tt_um_hoene_manchester_encoder
    import tt_um_hoene_manchester_encoder_pkg::*;
#(
    parameter int   HALF_W     = HALF_W_DEF,
    parameter int   GAP_HALVES = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HALF_W-1:0] half_period,
    input  logic              in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              out_busy,
    output logic              out_bit_done,
    output logic              out_underrun
);

    localparam int CNT_W = HALF_W + $clog2(GAP_HALVES) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_MULT = CNT_W'(GAP_HALVES);

    enc_state_t        r_state;
    enc_state_t        w_state_nxt;
    logic              r_data;
    logic              r_last;
    logic              r_out;
    logic [HALF_W-1:0] r_half;
    logic [HALF_W-1:0] w_half_in;
    logic              w_accept;
    logic              w_zero;
    logic              w_final;
    logic              w_data_nxt;
    logic              w_out_nxt;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic [CNT_W-1:0]  w_gap_total;
    logic              w_bit_done;
    logic              w_underrun;

    assign w_half_in   = (half_period == '0) ? HALF_W'(1) : half_period;
    assign w_final     = (r_state == ST_SECOND) && w_zero;
    assign in_ready    = !rst && ((r_state == ST_IDLE) || (w_final && !r_last));
    assign w_accept    = in_valid && in_ready;
    assign w_data_nxt  = w_accept ? in_data : r_data;
    assign w_gap_total = GAP_MULT * CNT_W'(r_half);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_bit_done  = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_FIRST;
                    w_load      = 1'b1;
                    w_load_val  = CNT_W'(w_half_in) - CNT_ONE;
                end
            end
            ST_FIRST: begin
                if (w_zero) begin
                    w_state_nxt = ST_SECOND;
                    w_load      = 1'b1;
                    w_load_val  = CNT_W'(r_half) - CNT_ONE;
                end
            end
            ST_SECOND: begin
                if (w_zero) begin
                    w_bit_done = 1'b1;
                    if (w_accept) begin
                        w_state_nxt = ST_FIRST;
                        w_load      = 1'b1;
                        w_load_val  = CNT_W'(w_half_in) - CNT_ONE;
                    end else if (r_last) begin
                        w_state_nxt = ST_GAP;
                        w_load      = 1'b1;
                        w_load_val  = w_gap_total - CNT_ONE;
                    end else begin
                        w_underrun  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // out is registered, so its next value follows the state being entered.
    always_comb begin
        w_out_nxt = IDLE_LEVEL;
        case (w_state_nxt)
            ST_FIRST:  w_out_nxt = first_half_level(w_data_nxt);
            ST_SECOND: w_out_nxt = ~first_half_level(r_data);
            default:   w_out_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_out   <= IDLE_LEVEL;
            r_data  <= 1'b0;
            r_last  <= 1'b0;
            r_half  <= HALF_W'(1);
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            if (w_accept) begin
                r_data <= in_data;
                r_last <= in_last;
                r_half <= w_half_in;
            end
        end
    end

    tt_um_hoene_halfbit_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    assign out          = r_out;
    assign out_busy     = (r_state != ST_IDLE);
    assign out_bit_done = w_bit_done && !rst;
    assign out_underrun = w_underrun && !rst;

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// Directed bench for the Manchester encoder; cycle k is counted from the accept cycle (k=0).
module tb_tt_um_hoene_manchester_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] half_period;
    logic       in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic       out;
    logic       out_busy;
    logic       out_bit_done;
    logic       out_underrun;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tt_um_hoene_manchester_encoder #(
        .HALF_W     (6),
        .GAP_HALVES (4),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .half_period  (half_period),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out          (out),
        .out_busy     (out_busy),
        .out_bit_done (out_bit_done),
        .out_underrun (out_underrun)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0; half_period = 6'd4;
        repeat (2) next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst = 1'b1; in_valid = 1'b1; in_data = 1'b1; in_last = 1'b0; half_period = 6'd4;
        repeat (2) next_cycle();
        #1;
        got = {out, out_busy, in_ready, out_bit_done, out_underrun};
        n_chk++;
        if (got !== 5'b00000) $display("FAIL reset_state got=%b exp=00000", got);
        else n_pass++;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        got = {out, out_busy, in_ready, out_bit_done, out_underrun};
        n_chk++;
        if (got !== 5'b00100) $display("FAIL reset_release got=%b exp=00100", got);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_single_bit();
        logic [3:0] got, exp;
        do_reset();
        half_period = 6'd4; in_data = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL single_idle_ready got=%b exp=1", in_ready);
        else n_pass++;
        for (int k = 1; k <= 25; k++) begin
            next_cycle();
            in_valid = 1'b0;
            #1;
            exp = {(k >= 5 && k <= 8), (k == 8), (k == 25), (k <= 24)};
            got = {out, out_bit_done, in_ready, out_busy};
            n_chk++;
            if (got !== exp) $display("FAIL single_bit k=%0d got=%b exp=%b", k, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  got, exp;
        logic [1:12] pat;
        pat = 12'b001100111100;
        do_reset();
        half_period = 6'd2; in_data = 1'b1; in_last = 1'b0; in_valid = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            next_cycle();
            if (k == 1) begin in_data = 1'b1; in_last = 1'b0; end
            if (k == 5) begin in_data = 1'b0; in_last = 1'b1; end
            if (k == 9) in_valid = 1'b0;
            #1;
            exp = {(k <= 12) ? pat[k] : 1'b0,
                   (k == 4 || k == 8 || k == 12),
                   (k == 4 || k == 8 || k == 21),
                   (k <= 20)};
            got = {out, out_bit_done, in_ready, out_busy};
            n_chk++;
            if (got !== exp) $display("FAIL back_to_back k=%0d got=%b exp=%b", k, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_underrun();
        logic [4:0] got, exp;
        do_reset();
        half_period = 6'd3; in_data = 1'b1; in_last = 1'b0; in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            in_valid = 1'b0;
            #1;
            exp = {(k >= 4 && k <= 6), (k == 6), (k == 6), (k >= 6), (k <= 6)};
            got = {out, out_bit_done, out_underrun, in_ready, out_busy};
            n_chk++;
            if (got !== exp) $display("FAIL underrun k=%0d got=%b exp=%b", k, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_zero_half();
        logic [3:0] got, exp;
        do_reset();
        half_period = 6'd0; in_data = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            in_valid = 1'b0;
            #1;
            exp = {(k == 1), (k == 2), (k == 7), (k <= 6)};
            got = {out, out_bit_done, in_ready, out_busy};
            n_chk++;
            if (got !== exp) $display("FAIL zero_half k=%0d got=%b exp=%b", k, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got, exp;
        do_reset();
        half_period = 6'd5; in_data = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            next_cycle();
            if (k == 1) in_valid = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 4) rst = 1'b0;
            if (k == 5) begin in_valid = 1'b1; in_data = 1'b1; in_last = 1'b1; end
            if (k == 6) in_valid = 1'b0;
            #1;
            if (k <= 3)       exp = 4'b1001;
            else if (k <= 5)  exp = 4'b0010;
            else if (k <= 10) exp = 4'b0001;
            else if (k <= 15) exp = {1'b1, (k == 15), 1'b0, 1'b1};
            else              exp = 4'b0001;
            got = {out, out_bit_done, in_ready, out_busy};
            n_chk++;
            if (got !== exp) $display("FAIL reset_mid k=%0d got=%b exp=%b", k, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_half_change();
        logic [3:0] got, exp;
        do_reset();
        half_period = 6'd4; in_data = 1'b1; in_last = 1'b0; in_valid = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            next_cycle();
            if (k == 1) in_valid = 1'b0;
            if (k == 5) begin half_period = 6'd6; in_valid = 1'b1; in_data = 1'b0; in_last = 1'b1; end
            if (k == 9) in_valid = 1'b0;
            #1;
            exp = {(k >= 5 && k <= 14), (k == 8 || k == 20), (k == 8), 1'b1};
            got = {out, out_bit_done, in_ready, out_busy};
            n_chk++;
            if (got !== exp) $display("FAIL half_change k=%0d got=%b exp=%b", k, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_back_to_back();
        test_underrun();
        test_zero_half();
        test_reset_mid();
        test_half_change();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
